// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit with a busy/done handshake.
// Multiply uses radix-4 Booth recoding, two multiplier bits per cycle.
// Divide uses restoring division on magnitudes, one quotient bit per cycle.
// The FIX state applies sign corrections and writes hi/lo on the way into DONE.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(W/2 - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(W - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t        state_reg;
  logic [1:0]    op_reg;
  logic [W-1:0]  a_reg;
  logic          b_msb_reg;
  logic          dbz_reg;
  logic [CW-1:0] cnt_reg;
  logic [W+1:0]  acc_reg;   // Booth partial-product accumulator (upper half)
  logic [W-1:0]  mpl_reg;   // multiplier being shifted out / product low half
  logic          qm1_reg;   // Booth look-behind bit
  logic [W-1:0]  rem_reg;
  logic [W-1:0]  quo_reg;
  logic [W-1:0]  dvs_reg;

  // Operand magnitudes captured at start; unsigned ops use raw values.
  logic         a_neg_in, b_neg_in;
  logic [W-1:0] a_mag_in, b_mag_in;
  assign a_neg_in = ~op[0] & a[W-1];
  assign b_neg_in = ~op[0] & b[W-1];
  assign a_mag_in = a_neg_in ? -a : a;
  assign b_mag_in = b_neg_in ? -b : b;

  // One Booth radix-4 step: add the recoded multiple of a, then shift right by 2.
  logic [2:0]   grp;
  logic [W+3:0] mcand;
  logic [W+3:0] pp;
  logic [W+3:0] sum;
  always_comb begin
    grp   = {mpl_reg[1:0], qm1_reg};
    mcand = op_reg[0] ? {4'b0000, a_reg} : {{4{a_reg[W-1]}}, a_reg};
    pp    = '0;
    case (grp)
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
    sum = {{2{acc_reg[W+1]}}, acc_reg} + pp;
  end

  // One restoring-division step on magnitudes.
  logic [W:0] shifted;
  logic       fits;
  assign shifted = {rem_reg, quo_reg[W-1]};
  assign fits    = shifted >= {1'b0, dvs_reg};

  // Final result with sign corrections. The Booth pass treats the multiplier
  // as signed, so MULU adds a<<W back when the multiplier's top bit is set.
  logic         a_neg_r, b_neg_r;
  logic [W-1:0] hi_fix, lo_fix;
  always_comb begin
    a_neg_r = ~op_reg[0] & a_reg[W-1];
    b_neg_r = ~op_reg[0] & b_msb_reg;
    if (dbz_reg) begin
      hi_fix = a_reg;
      lo_fix = '1;
    end else if (op_reg[1]) begin
      hi_fix = a_neg_r ? -rem_reg : rem_reg;
      lo_fix = (a_neg_r ^ b_neg_r) ? -quo_reg : quo_reg;
    end else begin
      hi_fix = acc_reg[W-1:0] + ((op_reg[0] && b_msb_reg) ? a_reg : '0);
      lo_fix = mpl_reg;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_reg   <= S_IDLE;
      op_reg      <= '0;
      a_reg       <= '0;
      b_msb_reg   <= 1'b0;
      dbz_reg     <= 1'b0;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      mpl_reg     <= '0;
      qm1_reg     <= 1'b0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvs_reg     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            op_reg    <= op;
            a_reg     <= a;
            b_msb_reg <= b[W-1];
            dbz_reg   <= op[1] && (b == '0);
            cnt_reg   <= '0;
            acc_reg   <= '0;
            mpl_reg   <= b;
            qm1_reg   <= 1'b0;
            rem_reg   <= '0;
            quo_reg   <= a_mag_in;
            dvs_reg   <= b_mag_in;
            busy      <= 1'b1;
            if (!op[1])         state_reg <= S_MUL;
            else if (b == '0)   state_reg <= S_FIX;
            else                state_reg <= S_DIV;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_MUL: begin
          acc_reg <= sum[W+3:2];
          mpl_reg <= {sum[1:0], mpl_reg[W-1:2]};
          qm1_reg <= mpl_reg[1];
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == MUL_LAST) state_reg <= S_FIX;
        end
        S_DIV: begin
          rem_reg <= fits ? (shifted[W-1:0] - dvs_reg) : shifted[W-1:0];
          quo_reg <= {quo_reg[W-2:0], fits};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == DIV_LAST) state_reg <= S_FIX;
        end
        S_FIX: begin
          hi          <= hi_fix;
          lo          <= lo_fix;
          div_by_zero <= dbz_reg;
          busy        <= 1'b0;
          done        <= 1'b1;
          state_reg   <= S_DONE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit (WIDTH=32) with hand-computed results.
module tb_mul_div_unit;

  logic        Clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [1:0] OP_MUL = 2'b00, OP_MULU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  mul_div_unit #(.WIDTH(32)) dut (
    .Clock(Clock), .clear(clear), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive a request so that the next rising edge (edge 0) samples it.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge Clock); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    check("busy_rise", {63'd0, busy}, 64'd1);
  endtask

  // Count edges after edge 0 until done is seen; -1 if the budget expires.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge Clock); #1;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int exp_lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz);
    int lat;
    @(negedge Clock);
    launch(o, x, y);
    wait_done(lat);
    $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b lat=%0d", tag, o, x, y, hi, lo, div_by_zero, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
    check({tag, "_busy_fall"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int lat, ndone, done_edge;

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    check("rst_outputs", {29'd0, busy, done, div_by_zero, hi, lo}, 64'd0);
    @(negedge Clock); clear = 1'b1;

    // Unsigned-range MUL and hold
    run_op("mul_12x6", OP_MUL, 32'd12, 32'd6, 17, 32'd0, 32'd72, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      check("hold", {hi, lo}, {32'd0, 32'd72});
    end
    check("hold_no_done", {63'd0, done}, 64'd0);

    // MUL extremes
    run_op("mul_m3x7", OP_MUL, 32'hFFFF_FFFD, 32'd7, 17, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mulu_max", OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mul_min2", OP_MUL, 32'h8000_0000, 32'h8000_0000, 17, 32'h4000_0000, 32'h0, 1'b0);

    // Divide signs
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 33, 32'd1, 32'h7FFF_FFFC, 1'b0);
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0);

    // Divide by zero, flag holds, then cleared by the next done
    run_op("div_by0", OP_DIV, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b1);
    repeat (3) @(negedge Clock);
    check("dbz_hold", {63'd0, div_by_zero}, 64'd1);
    run_op("mul_after_dbz", OP_MUL, 32'd2, 32'd3, 17, 32'd0, 32'd6, 1'b0);

    // Start pulses while busy are ignored
    @(negedge Clock);
    launch(OP_MUL, 32'd12, 32'd6);
    ndone = 0; done_edge = -1;
    for (int e = 1; e <= 30; e++) begin
      @(negedge Clock);
      start = (e == 3 || e == 10);
      op = OP_MUL; a = 32'd100; b = 32'd100;
      @(posedge Clock); #1;
      if (done) begin ndone++; done_edge = e; end
    end
    start = 1'b0;
    $display("busy_start ndone=%0d done_edge=%0d lo=%h", ndone, done_edge, lo);
    check("ignore_ndone", 64'(ndone), 64'd1);
    check("ignore_edge", 64'(done_edge), 64'd17);
    check("ignore_lo", {32'd0, lo}, 64'd72);

    // Back-to-back: accept a new op in the done cycle
    run_op("b2b_first", OP_MUL, 32'd9, 32'd9, 17, 32'd0, 32'd81, 1'b0);
    launch(OP_DIVU, 32'd100, 32'd7);
    check("b2b_done_low", {63'd0, done}, 64'd0);
    wait_done(lat);
    $display("b2b_second op=3 a=00000064 b=00000007 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
    check("b2b_lat", 64'(lat), 64'd33);
    check("b2b_result", {hi, lo}, {32'd2, 32'd14});

    // Reset in the middle of a divide
    @(negedge Clock);
    launch(OP_DIV, 32'd1000, 32'd3);
    repeat (8) @(posedge Clock);
    #1 clear = 1'b0;
    #1;
    $display("mid_reset busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    check("midrst_state", {30'd0, busy, done, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    @(negedge Clock); clear = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clock); #1;
      if (done) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    run_op("mul_after_rst", OP_MUL, 32'd12, 32'd6, 17, 32'd0, 32'd72, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
